// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the clock frequency/duty monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } mon_state_t;

    localparam int PCT_W     = 7;
    localparam int PCT_SCALE = 100;

endpackage

// File: rtl/clk_mon_div.sv
// Restoring divider, one quotient bit per clk; quotient ready exactly N_W clks after start.
// The first bit is resolved on the start edge itself, so busy covers N_W-1 further edges.
module clk_mon_div #(
    parameter int N_W = 23,
    parameter int D_W = 16,
    parameter int Q_W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [Q_W-1:0] quotient
);

    localparam int C_W = $clog2(N_W);

    logic [D_W-1:0] rem, rem_src, rem_step, dsr, dsr_src;
    logic [N_W-1:0] quo, quo_src, quo_step;
    logic [D_W:0]   shifted;
    logic [C_W-1:0] cnt;
    logic           load;

    assign load     = start && !busy;
    assign quotient = quo[Q_W-1:0];

    always_comb begin
        rem_src = load ? '0 : rem;
        quo_src = load ? dividend : quo;
        dsr_src = load ? divisor : dsr;
        shifted = {rem_src, quo_src[N_W-1]};
        if (shifted >= {1'b0, dsr_src}) begin
            rem_step = D_W'(shifted - {1'b0, dsr_src});
            quo_step = {quo_src[N_W-2:0], 1'b1};
        end else begin
            rem_step = shifted[D_W-1:0];
            quo_step = {quo_src[N_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            rem  <= '0;
            quo  <= '0;
            dsr  <= '0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                rem  <= rem_step;
                quo  <= quo_step;
                dsr  <= divisor;
                cnt  <= C_W'(N_W - 1);
                busy <= 1'b1;
            end else if (busy) begin
                rem <= rem_step;
                quo <= quo_step;
                cnt <= cnt - 1'b1;
                if (cnt == C_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clk_freq_duty_monitor.sv
// Oversampling period/high-time/duty monitor with stuck-input timeout.
// DUTY_CALC_EN adds the duty divider and overrun flag; otherwise duty_pct=0, overrun=0.
//   state | meaning
//   IDLE  | disabled, counters cleared
//   ARM   | waiting for the arming rise (not reported)
//   HIGH  | counting period and high phase
//   LOW   | counting period, capture on next rise
module clk_freq_duty_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [PCT_W-1:0] duty_pct,
    output logic             valid,
    output logic             timeout,
    output logic             overrun
);

    mon_state_t             state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise, fall;
    logic [CNT_W-1:0]       cnt_p, cnt_h, cnt_p_nxt, cnt_h_nxt, cnt_p_inc;
    logic                   capture, sat, arm_rise;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt_p <= '0;
            cnt_h <= '0;
        end else begin
            state <= state_nxt;
            cnt_p <= cnt_p_nxt;
            cnt_h <= cnt_h_nxt;
        end
    end

    // Saturation wins over a rise in HIGH/LOW so the longest reportable period is 2^CNT_W-2.
    always_comb begin
        state_nxt = state;
        cnt_p_nxt = cnt_p;
        cnt_h_nxt = cnt_h;
        capture   = 1'b0;
        sat       = 1'b0;
        arm_rise  = 1'b0;
        cnt_p_inc = cnt_p + 1'b1;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_p_nxt = '0;
            cnt_h_nxt = '0;
        end else if (state == IDLE) begin
            state_nxt = ARM;
            cnt_p_nxt = '0;
            cnt_h_nxt = '0;
        end else if (rise && state == ARM) begin
            arm_rise  = 1'b1;
            state_nxt = HIGH;
            cnt_p_nxt = '0;
            cnt_h_nxt = '0;
        end else if (cnt_p_inc == {CNT_W{1'b1}}) begin
            sat       = 1'b1;
            state_nxt = ARM;
            cnt_p_nxt = '0;
            cnt_h_nxt = '0;
        end else if (rise) begin
            capture   = 1'b1;
            state_nxt = HIGH;
            cnt_p_nxt = '0;
            cnt_h_nxt = '0;
        end else begin
            cnt_p_nxt = cnt_p_inc;
            if (state == HIGH) begin
                cnt_h_nxt = cnt_h + 1'b1;
                if (fall) state_nxt = LOW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) timeout <= 1'b0;
        else if (sat)          timeout <= 1'b1;
        else if (arm_rise)     timeout <= 1'b0;
    end

`ifdef DUTY_CALC_EN
    localparam int DIV_W = CNT_W + PCT_W;

    logic             div_start, div_busy, div_done;
    logic [PCT_W-1:0] div_q;
    logic [DIV_W-1:0] dividend;
    logic [CNT_W-1:0] pend_p, pend_h;

    assign div_start = capture && !div_busy;
    assign dividend  = DIV_W'(cnt_h) * DIV_W'(PCT_SCALE);

    // Disabling aborts any division in flight so held outputs stay untouched.
    clk_mon_div #(
        .N_W (DIV_W),
        .D_W (CNT_W),
        .Q_W (PCT_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n && enable),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (cnt_p_inc),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_p    <= '0;
            pend_h    <= '0;
            period    <= '0;
            high_time <= '0;
            duty_pct  <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
        end else if (!enable) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (div_start) begin
                pend_p <= cnt_p_inc;
                pend_h <= cnt_h;
            end
            if (capture && div_busy) overrun <= 1'b1;
            if (div_done) begin
                period    <= pend_p;
                high_time <= pend_h;
                duty_pct  <= div_q;
                valid     <= 1'b1;
            end
        end
    end
`else
    assign duty_pct = '0;
    assign overrun  = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (capture) begin
                period    <= cnt_p_inc;
                high_time <= cnt_h;
                valid     <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_clk_freq_duty_monitor.sv
// Randomized bench for clk_freq_duty_monitor (CNT_W=8) against a rise-time scoreboard model.
module tb_clk_freq_duty_monitor;

    localparam int CNT_W   = 8;
    localparam int SYNC    = 2;
    localparam int DIV_CYC = CNT_W + 7;
`ifdef DUTY_CALC_EN
    localparam bit DUTY_ON = 1'b1;
`else
    localparam bit DUTY_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period, high_time;
    logic [6:0]       duty_pct;
    logic             valid, timeout, overrun;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ph = 0;
    logic prev_s = 1'b0;
    int   rise_q[$], vt_q[$], vp_q[$], vh_q[$], vd_q[$], exp_q[$];
    int   exp_drops;

    clk_freq_duty_monitor #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .duty_pct  (duty_pct),
        .valid     (valid),
        .timeout   (timeout),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // One clk of stimulus; records driven rises and every observed valid pulse.
    task automatic step(input logic s);
        sig_in = s;
        if (s && !prev_s) rise_q.push_back(cyc);
        prev_s = s;
        @(posedge clk);
        #1;
        if (valid === 1'b1) begin
            vt_q.push_back(cyc);
            vp_q.push_back(int'(period));
            vh_q.push_back(int'(high_time));
            vd_q.push_back(int'(duty_pct));
        end
        cyc++;
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            step(ph < h);
            ph = (ph + 1) % p;
        end
    endtask

    task automatic clear_rec();
        rise_q.delete();
        vt_q.delete();
        vp_q.delete();
        vh_q.delete();
        vd_q.delete();
    endtask

    task automatic restart();
        enable = 1'b0;
        repeat (4) step(1'b0);
        enable = 1'b1;
        repeat (2) step(1'b0);
        ph = 0;
        clear_rec();
    endtask

    // Reference: the first rise arms; every later rise is seen SYNC clks later and reported
    // then, or, with the divider, DIV_CYC clks after being accepted; captures landing while
    // a division is still running are dropped.
    function automatic void build_expect(input int limit);
        int busy_until;
        busy_until = -1;
        exp_q.delete();
        exp_drops = 0;
        for (int k = 1; k < rise_q.size(); k++) begin
            int c;
            c = rise_q[k] + SYNC;
            if (c < limit) begin
                if (!DUTY_ON) begin
                    exp_q.push_back(c);
                end else if (c >= busy_until) begin
                    busy_until = c + DIV_CYC;
                    if (busy_until < limit) exp_q.push_back(busy_until);
                end else begin
                    exp_drops++;
                end
            end
        end
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sig_in = i[0];
            @(posedge clk);
            #1;
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid cycle %0d: got %b exp 0", i, valid);
            end
        end
        checks++;
        if (period !== '0 || high_time !== '0 || duty_pct !== '0 || timeout !== 1'b0 ||
            overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got per=%0d hi=%0d duty=%0d to=%b ov=%b exp all 0",
                     period, high_time, duty_pct, timeout, overrun);
        end
        rst_n  = 1'b1;
        enable = 1'b0;
        prev_s = 1'b1;
        repeat (3) step(1'b0);
    endtask

    task automatic test_patterns();
        int pp[$];
        int hh[$];
        pp = '{10, 100};
        hh = '{6, 25};
        for (int i = 0; i < 4; i++) begin
            int p;
            p = int'($urandom_range(90, 3));
            pp.push_back(p);
            hh.push_back(int'($urandom_range(p - 1, 1)));
        end
        for (int t = 0; t < pp.size(); t++) begin
            int p;
            int h;
            int ed;
            p  = pp[t];
            h  = hh[t];
            ed = DUTY_ON ? (h * 100) / p : 0;
            restart();
            wave(p, h, 4 * p);
            build_expect(cyc);
            checks++;
            if (vt_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL pattern_count p=%0d h=%0d: got %0d valids exp %0d",
                         p, h, vt_q.size(), exp_q.size());
            end
            for (int i = 0; i < vt_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (vt_q[i] != exp_q[i] || vp_q[i] != p || vh_q[i] != h || vd_q[i] != ed) begin
                    errors++;
                    $display("FAIL pattern_valid[%0d] p=%0d h=%0d: got t=%0d per=%0d hi=%0d duty=%0d exp t=%0d per=%0d hi=%0d duty=%0d",
                             i, p, h, vt_q[i], vp_q[i], vh_q[i], vd_q[i], exp_q[i], p, h, ed);
                end
            end
            checks++;
            if (overrun !== (exp_drops > 0)) begin
                errors++;
                $display("FAIL pattern_overrun p=%0d h=%0d: got %b exp %b",
                         p, h, overrun, exp_drops > 0);
            end
        end
    endtask

    task automatic test_timeout();
        int last_r;
        int t_first;
        int r1;
        restart();
        wave(20, 10, 40);
        step(1'b1);
        last_r  = rise_q[rise_q.size() - 1];
        t_first = -1;
        for (int i = 0; i < 300; i++) begin
            step(1'b1);
            if (timeout === 1'b1 && t_first < 0) t_first = cyc - 1;
        end
        checks++;
        if (t_first < last_r + 250 || t_first > last_r + SYNC + 255) begin
            errors++;
            $display("FAIL timeout_latency: got first timeout at %0d exp within [%0d,%0d]",
                     t_first, last_r + 250, last_r + SYNC + 255);
        end
        checks++;
        if (timeout !== 1'b1 || period !== 8'd20 || high_time !== 8'd10) begin
            errors++;
            $display("FAIL timeout_hold: got to=%b per=%0d hi=%0d exp to=1 per=20 hi=10",
                     timeout, period, high_time);
        end
        clear_rec();
        ph = 10;
        r1 = cyc + 10;
        for (int i = 0; i < 60; i++) begin
            step(ph < 10);
            ph = (ph + 1) % 20;
            if (cyc - 1 == r1 + 1) begin
                checks++;
                if (timeout !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_before_rise: got %b exp 1", timeout);
                end
            end
            if (cyc - 1 == r1 + SYNC) begin
                checks++;
                if (timeout !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_clear: got %b exp 0", timeout);
                end
            end
        end
        build_expect(cyc);
        checks++;
        if (vt_q.size() == 0 || exp_q.size() == 0 || vt_q[0] != exp_q[0] || vp_q[0] != 20) begin
            errors++;
            $display("FAIL timeout_recover: got %0d valids first t=%0d per=%0d exp t=%0d per=20",
                     vt_q.size(), vt_q.size() ? vt_q[0] : -1, vp_q.size() ? vp_q[0] : -1,
                     exp_q.size() ? exp_q[0] : -1);
        end
    endtask

    task automatic test_enable_drop();
        int hp;
        int hh;
        int hd;
        restart();
        wave(10, 6, 35);
        hp = int'(period);
        hh = int'(high_time);
        hd = int'(duty_pct);
        clear_rec();
        enable = 1'b0;
        wave(10, 6, 3);
        checks++;
        if (vt_q.size() != 0 || timeout !== 1'b0 || int'(period) != hp ||
            int'(high_time) != hh || int'(duty_pct) != hd) begin
            errors++;
            $display("FAIL drop_hold: got valids=%0d to=%b per=%0d hi=%0d duty=%0d exp 0 0 %0d %0d %0d",
                     vt_q.size(), timeout, period, high_time, duty_pct, hp, hh, hd);
        end
        clear_rec();
        enable = 1'b1;
        wave(10, 6, 40);
        build_expect(cyc);
        checks++;
        if (vt_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL drop_count: got %0d valids exp %0d", vt_q.size(), exp_q.size());
        end
        checks++;
        if (vt_q.size() == 0 || exp_q.size() == 0 || vt_q[0] != exp_q[0] ||
            vp_q[0] != 10 || vh_q[0] != 6) begin
            errors++;
            $display("FAIL drop_first_valid: got t=%0d per=%0d hi=%0d exp t=%0d per=10 hi=6",
                     vt_q.size() ? vt_q[0] : -1, vp_q.size() ? vp_q[0] : -1,
                     vh_q.size() ? vh_q[0] : -1, exp_q.size() ? exp_q[0] : -1);
        end
    endtask

    task automatic test_overrun();
        int ed;
        ed = DUTY_ON ? 50 : 0;
        restart();
        wave(4, 2, 80);
        build_expect(cyc);
        checks++;
        if (vt_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL overrun_count: got %0d valids exp %0d", vt_q.size(), exp_q.size());
        end
        for (int i = 0; i < vt_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (vt_q[i] != exp_q[i] || vp_q[i] != 4 || vh_q[i] != 2 || vd_q[i] != ed) begin
                errors++;
                $display("FAIL overrun_valid[%0d]: got t=%0d per=%0d hi=%0d duty=%0d exp t=%0d per=4 hi=2 duty=%0d",
                         i, vt_q[i], vp_q[i], vh_q[i], vd_q[i], exp_q[i], ed);
            end
        end
        checks++;
        if (overrun !== (exp_drops > 0)) begin
            errors++;
            $display("FAIL overrun_flag: got %b exp %b", overrun, exp_drops > 0);
        end
        enable = 1'b0;
        step(1'b0);
        checks++;
        if (overrun !== 1'b0 || timeout !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got ov=%b to=%b valid=%b exp 0 0 0",
                     overrun, timeout, valid);
        end
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_timeout();
        test_enable_drop();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
